// File: rtl/cntr_mux_sr_pkg.sv
// Shared constants and helpers for the cntr_mux_sr bit-serializer.
package cntr_mux_sr_pkg;

    localparam int unsigned WIDTH_DEF    = 8;
    localparam int unsigned SR_DEPTH_DEF = 4;

    // Number of bits needed to address v items (v >= 2).
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cntr_mux_sr_shreg.sv
// SR_DEPTH-bit shift register with synchronous clear and advance enable.
module cntr_mux_sr_shreg
    import cntr_mux_sr_pkg::*;
#(
    parameter int unsigned SR_DEPTH = SR_DEPTH_DEF
) (
    input  logic clk,
    input  logic res,
    input  logic en,
    input  logic d,
    output logic q
);

    logic [SR_DEPTH-1:0] sr;

    always_ff @(posedge clk) begin
        if (res) begin
            sr <= '0;
        end else if (en) begin
            sr <= {sr[SR_DEPTH-2:0], d};
        end
    end

    // Output comes straight off the last flop.
    assign q = sr[SR_DEPTH-1];

endmodule

// File: rtl/cntr_mux_sr.sv
// Bit-serializer: select counter + N:1 mux feeding a fixed-latency shift register.
// Define CNTR_MUX_SR_DOWN_EN for a down-counting select (MSB-first output).
module cntr_mux_sr
    import cntr_mux_sr_pkg::*;
#(
    parameter int unsigned WIDTH    = WIDTH_DEF,
    parameter int unsigned SR_DEPTH = SR_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             res,
    input  logic             en,
    input  logic [WIDTH-1:0] in,
    output logic             out
);

    localparam int unsigned SEL_W = clog2(WIDTH);

`ifdef CNTR_MUX_SR_DOWN_EN
    localparam logic [SEL_W-1:0] CNT_RST = SEL_W'(WIDTH - 1);
`else
    localparam logic [SEL_W-1:0] CNT_RST = '0;
`endif

    logic [SEL_W-1:0] cnt;
    logic             bit_sel_c;

    // WIDTH is a power of two, so natural wrap of cnt gives modulo-WIDTH stepping.
    always_ff @(posedge clk) begin
        if (res) begin
            cnt <= CNT_RST;
        end else if (en) begin
`ifdef CNTR_MUX_SR_DOWN_EN
            cnt <= cnt - SEL_W'(1);
`else
            cnt <= cnt + SEL_W'(1);
`endif
        end
    end

    assign bit_sel_c = in[cnt];

    cntr_mux_sr_shreg #(
        .SR_DEPTH(SR_DEPTH)
    ) u_shreg (
        .clk(clk),
        .res(res),
        .en (en),
        .d  (bit_sel_c),
        .q  (out)
    );

endmodule

// File: tb/tb_cntr_mux_sr.sv
// Directed self-checking bench for cntr_mux_sr (WIDTH=8, SR_DEPTH=4).
module tb_cntr_mux_sr;

    logic       clk = 1'b0;
    logic       res;
    logic       en;
    logic [7:0] in;
    logic       out;

    int checks   = 0;
    int failures = 0;

    // Expected output sequences after the 4-edge latency, hand-derived per pattern.
`ifdef CNTR_MUX_SR_DOWN_EN
    localparam logic [2:0] CNT_RST  = 3'd7;
    localparam logic [2:0] CNT_AT5  = 3'd2;
    localparam logic [2:0] CNT_AT10 = 3'd5;
    localparam logic [7:0] SEQ_A5   = 8'hA5;
    localparam logic [7:0] SEQ_0F   = 8'hF0;
    localparam logic [7:0] SEQ_81   = 8'h81;
    localparam logic [7:0] SEQ_01   = 8'h80;
`else
    localparam logic [2:0] CNT_RST  = 3'd0;
    localparam logic [2:0] CNT_AT5  = 3'd5;
    localparam logic [2:0] CNT_AT10 = 3'd2;
    localparam logic [7:0] SEQ_A5   = 8'hA5;
    localparam logic [7:0] SEQ_0F   = 8'h0F;
    localparam logic [7:0] SEQ_81   = 8'h81;
    localparam logic [7:0] SEQ_01   = 8'h01;
`endif

    cntr_mux_sr #(
        .WIDTH   (8),
        .SR_DEPTH(4)
    ) dut (
        .clk(clk),
        .res(res),
        .en (en),
        .in (in),
        .out(out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        res = 1'b1;
        tick();
        res = 1'b0;
        check("rst_out", 32'(out), 32'd0);
        check("rst_cnt", 32'(dut.cnt), 32'(CNT_RST));
    endtask

    // Enabled edges first..last (0-based since reset); seq[j] is the j-th serial bit.
    task automatic run_edges(input string tag, input logic [7:0] seq, input int first, input int last);
        logic [7:0] s;
        s = seq;
        en = 1'b1;
        for (int i = first; i <= last; i++) begin
            tick();
            if (i < 3) check(tag, 32'(out), 32'd0);
            else       check(tag, 32'(out), 32'(s[3'((i - 3) % 8)]));
        end
    endtask

    function automatic int bit_idx(input int k);
`ifdef CNTR_MUX_SR_DOWN_EN
        return 7 - (k % 8);
`else
        return k % 8;
`endif
    endfunction

    logic [7:0] hist [256];

    initial begin
        res = 1'b1;
        en  = 1'b1;
        in  = 8'hFF;

        // Reset held two edges with en=1 and all-ones input
        tick();
        check("rst1_out", 32'(out), 32'd0);
        check("rst1_cnt", 32'(dut.cnt), 32'(CNT_RST));
        tick();
        check("rst2_out", 32'(out), 32'd0);
        check("rst2_cnt", 32'(dut.cnt), 32'(CNT_RST));

        res = 1'b0;
        in  = 8'hA5;
        run_edges("a5", SEQ_A5, 0, 18);

        // Walking input: a new value every edge
        en = 1'b1;
        do_reset();
        for (int j = 0; j < 259; j++) begin
            if (j < 256) begin
                in      = 8'(j);
                hist[j] = 8'(j);
            end else begin
                in = 8'h00;
            end
            tick();
            if (j < 3) check("walk", 32'(out), 32'd0);
            else       check("walk", 32'(out), 32'(hist[j - 3][bit_idx(j - 3)]));
        end

        // Enable stall mid-stream
        do_reset();
        in = 8'h0F;
        run_edges("stall_pre", SEQ_0F, 0, 9);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_out", 32'(out), 32'(SEQ_0F[6]));
            check("stall_cnt", 32'(dut.cnt), 32'(CNT_AT10));
        end
        run_edges("stall_post", SEQ_0F, 10, 17);

        // Reset pulse at cnt=5 while enabled
        do_reset();
        in = 8'h81;
        run_edges("mrst_pre", SEQ_81, 0, 4);
        check("mrst_cnt5", 32'(dut.cnt), 32'(CNT_AT5));
        en  = 1'b1;
        res = 1'b1;
        tick();
        res = 1'b0;
        check("mrst_out", 32'(out), 32'd0);
        check("mrst_cnt", 32'(dut.cnt), 32'(CNT_RST));
        run_edges("mrst_post", SEQ_81, 0, 6);

        // Single-bit pattern exposes serialization order
        do_reset();
        in = 8'h01;
        run_edges("p01", SEQ_01, 0, 19);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
